// File: rtl/fixed_predictor_if.sv
// Sample stream between the residual decoder and the fixed-predictor reconstructor.
// The master drives config plus residuals; the slave returns reconstructed PCM.
interface fixed_predictor_if #(parameter int DATA_W = 16);
   logic                     enable;
   logic [2:0]               order;
   logic [15:0]              block_size;
   logic signed [DATA_W-1:0] data;
   logic                     valid;
   logic signed [DATA_W-1:0] sample;
   logic                     sample_valid;
   logic                     frame_done;
   logic                     error;

   modport master (
      output enable, order, block_size, data, valid,
      input  sample, sample_valid, frame_done, error
   );
   modport slave (
      input  enable, order, block_size, data, valid,
      output sample, sample_valid, frame_done, error
   );
endinterface

// File: rtl/fixed_predictor.sv
// FLAC FIXED-subframe reconstructor: warm-up passthrough, then order 0..4 polynomial
// prediction plus residual, with a registered sample strobe and end-of-block pulse.
module fixed_predictor #(
   parameter int DATA_W = 16,
   parameter int ACC_W  = 20
) (
   input logic clk,
   input logic rst,
   fixed_predictor_if.slave bus
);
   typedef enum logic [1:0] {IDLE, WARMUP, PREDICT, DONE} state_t;

   state_t                   state;
   logic [2:0]               ord;
   logic [16:0]              blk;
   logic [16:0]              cnt;
   logic signed [DATA_W-1:0] h1, h2, h3, h4;

   logic signed [ACC_W-1:0]  e1, e2, e3, e4, pred, sum;
   logic signed [DATA_W-1:0] recon, shin;
   logic [16:0]              cnt_nx;
   logic                     last;

   always_comb begin
      e1   = ACC_W'(h1);
      e2   = ACC_W'(h2);
      e3   = ACC_W'(h3);
      e4   = ACC_W'(h4);
      pred = '0;
      case (ord)
         3'd1: pred = e1;
         3'd2: pred = (e1 <<< 1) - e2;
         3'd3: pred = (e1 <<< 1) + e1 - (e2 <<< 1) - e2 + e3;
         3'd4: pred = (e1 <<< 2) - (e2 <<< 2) - (e2 <<< 1) + (e3 <<< 2) - e4;
         default: pred = '0;
      endcase
      sum    = pred + ACC_W'($signed(bus.data));
      recon  = sum[DATA_W-1:0];
      // warm-up samples pass through; predicted ones feed the history with the wrapped output
      shin   = (state == PREDICT) ? recon : bus.data;
      cnt_nx = cnt + 17'd1;
      last   = (cnt_nx == blk);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= IDLE;
         ord              <= '0;
         blk              <= '0;
         cnt              <= '0;
         h1               <= '0;
         h2               <= '0;
         h3               <= '0;
         h4               <= '0;
         bus.sample       <= '0;
         bus.sample_valid <= 1'b0;
         bus.frame_done   <= 1'b0;
         bus.error        <= 1'b0;
      end else begin
         bus.sample_valid <= 1'b0;
         bus.frame_done   <= 1'b0;
         if (!bus.enable) begin
            state <= IDLE;
         end else begin
            case (state)
               IDLE: begin
                  ord <= bus.order;
                  blk <= (bus.block_size == 16'd0) ? 17'h10000 : {1'b0, bus.block_size};
                  cnt <= '0;
                  h1  <= '0;
                  h2  <= '0;
                  h3  <= '0;
                  h4  <= '0;
                  if (bus.order > 3'd4) begin
                     state     <= DONE;
                     bus.error <= 1'b1;
                  end else if (bus.order == 3'd0) begin
                     state <= PREDICT;
                  end else begin
                     state <= WARMUP;
                  end
               end
               WARMUP, PREDICT: begin
                  if (bus.valid) begin
                     bus.sample       <= shin;
                     bus.sample_valid <= 1'b1;
                     h4  <= h3;
                     h3  <= h2;
                     h2  <= h1;
                     h1  <= shin;
                     cnt <= cnt_nx;
                     // a block shorter than the order ends inside warm-up
                     if (last) begin
                        bus.frame_done <= 1'b1;
                        state          <= DONE;
                     end else if (state == WARMUP && cnt_nx == {14'd0, ord}) begin
                        state <= PREDICT;
                     end
                  end
               end
               DONE: state <= DONE;
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule
